// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code conversion blocks: default width,
// arbiter FSM state type and a fixed-width binary-to-Gray helper.
package gray_pkg;

    localparam int W_DEFAULT = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic logic [W_DEFAULT-1:0] bin2gray(input logic [W_DEFAULT-1:0] i_bin);
        return i_bin ^ (i_bin >> 1);
    endfunction

endpackage

// File: rtl/gray_conv_arbiter_bin2gray_w.sv
// Parameterized combinational binary-to-Gray converter.
module bin2gray_w #(
    parameter int W = 3
) (
    input  logic [W-1:0] i_bin,
    output logic [W-1:0] o_gray
);

    assign o_gray[W-1] = i_bin[W-1];

    for (genvar g = 0; g < W-1; g++) begin : g_bit
        assign o_gray[g] = i_bin[g+1] ^ i_bin[g];
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Two-requester round-robin arbiter feeding one shared binary-to-Gray
// converter, with a single registered result slot on a valid/ready output.
module gray_conv_arbiter
    import gray_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [1:0]   i_req_valid,
    input  logic [W-1:0] i_req_data0,
    input  logic [W-1:0] i_req_data1,
    output logic [1:0]   o_req_ready,
    output logic         o_resp_valid,
    output logic [W-1:0] o_resp_gray,
    output logic         o_resp_id,
    input  logic         i_resp_ready
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_gray;
    logic         r_id;
    logic         r_last_id;

    logic         w_can_accept;
    logic         w_winner;
    logic         w_grant;
    logic [W-1:0] w_operand;
    logic [W-1:0] w_gray;

    assign w_can_accept = (r_state == EMPTY) || i_resp_ready;

    // On a tie the requester that did not win last time goes first.
    assign w_winner  = (&i_req_valid) ? ~r_last_id : i_req_valid[1];
    assign w_grant   = w_can_accept && (|i_req_valid);
    assign w_operand = w_winner ? i_req_data1 : i_req_data0;

    bin2gray_w #(
        .W (W)
    ) u_bin2gray (
        .i_bin  (w_operand),
        .o_gray (w_gray)
    );

    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = 2'b00;
        if (w_grant) begin
            o_req_ready[w_winner] = 1'b1;
        end
        case (r_state)
            EMPTY: begin
                if (w_grant) begin
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                if (i_resp_ready && !w_grant) begin
                    w_state_nxt = EMPTY;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= EMPTY;
            r_gray    <= '0;
            r_id      <= 1'b0;
            r_last_id <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_gray    <= w_gray;
                r_id      <= w_winner;
                r_last_id <= w_winner;
            end
        end
    end

    assign o_resp_valid = (r_state == FULL);
    assign o_resp_gray  = r_gray;
    assign o_resp_id    = r_id;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench for gray_conv_arbiter: directed vectors push expected
// responses, a negedge monitor pops them on every valid&ready transfer.
module tb_gray_conv_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [2:0] req_data0;
    logic [2:0] req_data1;
    logic [1:0] req_ready;
    logic       resp_valid;
    logic [2:0] resp_gray;
    logic       resp_id;
    logic       resp_ready;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] sb_q[$];   // {id, gray}

    gray_conv_arbiter #(.W(3)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .i_req_data0  (req_data0),
        .i_req_data1  (req_data1),
        .o_req_ready  (req_ready),
        .o_resp_valid (resp_valid),
        .o_resp_gray  (resp_gray),
        .o_resp_id    (resp_id),
        .i_resp_ready (resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer happens at the next posedge when valid&ready now.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_resp: got id=%0d gray=%b, expected none", resp_id, resp_gray);
            end else begin
                logic [3:0] e;
                e = sb_q.pop_front();
                check("resp_id", {7'd0, resp_id}, {7'd0, e[3]});
                check("resp_gray", {5'd0, resp_gray}, {5'd0, e[2:0]});
            end
        end
    end

    // One cycle of stimulus: drive after posedge, check req_ready at negedge.
    task automatic cyc(input logic [1:0] v, input logic [2:0] d0, input logic [2:0] d1,
                       input logic rr, input logic [1:0] exp_rdy,
                       input logic push, input logic exp_id, input logic [2:0] exp_g);
        @(posedge clk);
        #1;
        req_valid  = v;
        req_data0  = d0;
        req_data1  = d1;
        resp_ready = rr;
        @(negedge clk);
        check("req_ready", {6'd0, req_ready}, {6'd0, exp_rdy});
        if (push) sb_q.push_back({exp_id, exp_g});
    endtask

    task automatic idle(input logic rr);
        cyc(2'b00, 3'd0, 3'd0, rr, 2'b00, 1'b0, 1'b0, 3'd0);
    endtask

    logic [2:0] gray_tbl [8];

    initial begin
        gray_tbl = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
        rst        = 1'b1;
        req_valid  = 2'b00;
        req_data0  = 3'd0;
        req_data1  = 3'd0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", {7'd0, resp_valid}, 8'd0);
        check("rst_gray", {5'd0, resp_gray}, 8'd0);
        check("rst_id", {7'd0, resp_id}, 8'd0);

        // First transaction
        cyc(2'b01, 3'b110, 3'b000, 1'b1, 2'b01, 1'b1, 1'b0, 3'b101);
        idle(1'b1);

        // Exhaustive single requester, back to back
        for (int i = 0; i < 8; i++) begin
            cyc(2'b01, 3'(i), 3'd0, 1'b1, 2'b01, 1'b1, 1'b0, gray_tbl[i]);
        end
        idle(1'b1);

        // Single requester 1 wins alone, leaving last_id=1
        cyc(2'b10, 3'b000, 3'b101, 1'b1, 2'b10, 1'b1, 1'b1, 3'b111);
        // Continuous tie alternates 0,1,0,1
        cyc(2'b11, 3'b011, 3'b100, 1'b1, 2'b01, 1'b1, 1'b0, 3'b010);
        cyc(2'b11, 3'b011, 3'b100, 1'b1, 2'b10, 1'b1, 1'b1, 3'b110);
        cyc(2'b11, 3'b011, 3'b100, 1'b1, 2'b01, 1'b1, 1'b0, 3'b010);
        cyc(2'b11, 3'b011, 3'b100, 1'b1, 2'b10, 1'b1, 1'b1, 3'b110);
        idle(1'b1);

        // Backpressure: hold 111 from requester 0, then stall with a tie pending
        cyc(2'b01, 3'b101, 3'b000, 1'b1, 2'b01, 1'b1, 1'b0, 3'b111);
        for (int i = 0; i < 3; i++) begin
            cyc(2'b11, 3'b011, 3'b100, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0);
            check("stall_valid", {7'd0, resp_valid}, 8'd1);
            check("stall_gray", {5'd0, resp_gray}, 8'b111);
            check("stall_id", {7'd0, resp_id}, 8'd0);
        end
        cyc(2'b11, 3'b011, 3'b100, 1'b1, 2'b10, 1'b1, 1'b1, 3'b110);
        idle(1'b1);

        // Withdraw: requester 1 pulses valid while the output is stalled
        cyc(2'b01, 3'b001, 3'b000, 1'b1, 2'b01, 1'b1, 1'b0, 3'b001);
        idle(1'b0);
        cyc(2'b10, 3'b000, 3'b111, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        check("drained", 8'(sb_q.size()), 8'd0);

        // Mid-operation reset while FULL discards the held result
        cyc(2'b01, 3'b010, 3'b000, 1'b1, 2'b01, 1'b1, 1'b0, 3'b011);
        @(posedge clk);
        #1;
        req_valid  = 2'b00;
        resp_ready = 1'b0;
        #2;
        check("full_before_rst", {7'd0, resp_valid}, 8'd1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", {7'd0, resp_valid}, 8'd0);
        check("async_rst_gray", {5'd0, resp_gray}, 8'd0);
        sb_q.delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
        cyc(2'b11, 3'b011, 3'b100, 1'b1, 2'b01, 1'b1, 1'b0, 3'b010);
        idle(1'b1);
        idle(1'b1);
        check("final_empty", 8'(sb_q.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
